// File: rtl/flag_status_unit_if.sv
// Bus bundle for flag_status_unit: ALU observation inputs, flag/stack controls and status outputs.
interface flag_status_unit_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry_in;
  logic             sub;
  logic             update;
  logic             push;
  logic             pop;
  logic             clr_sticky;
  logic [3:0]       cond;

  logic             n;
  logic             z;
  logic             c;
  logic             v;
  logic             sticky_v;
  logic             cond_true;
  logic [CW-1:0]    depth_cnt;
  logic             stack_full;
  logic             stack_empty;
  logic             stack_err;

  modport master (
    output result, op_a, op_b, carry_in, sub, update, push, pop, clr_sticky, cond,
    input  n, z, c, v, sticky_v, cond_true, depth_cnt, stack_full, stack_empty, stack_err
  );

  modport slave (
    input  result, op_a, op_b, carry_in, sub, update, push, pop, clr_sticky, cond,
    output n, z, c, v, sticky_v, cond_true, depth_cnt, stack_full, stack_empty, stack_err
  );
endinterface

// File: rtl/flag_status_unit.sv
// NZCV flag register with a small LIFO flag stack, sticky overflow/misuse bits
// and a condition-code evaluator over the registered flags.
module flag_status_unit #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  flag_status_unit_if.slave   bus
);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SLOTS = 1 << IW;

  logic [3:0]    flags_q;
  logic [CW-1:0] depth_q;
  logic          sticky_q;
  logic          err_q;
  logic [3:0]    stack_mem [SLOTS];

  logic          a_msb, b_msb, r_msb;
  logic          nn, nz, nc, nv;
  logic          full, empty;
  logic          push_ok, pop_ok, misuse, v_set;
  logic [IW-1:0] push_idx, pop_idx;
  logic          cond_eval;

  assign a_msb = bus.op_a[WIDTH-1];
  assign b_msb = bus.op_b[WIDTH-1];
  assign r_msb = bus.result[WIDTH-1];

  assign nn = r_msb;
  assign nz = ~|bus.result;
  assign nc = bus.carry_in;
  // op_b is the un-inverted operand, so subtract overflows when the operand signs differ.
  assign nv = bus.sub ? ((a_msb ^ b_msb) & (a_msb ^ r_msb))
                      : ((a_msb ~^ b_msb) & (a_msb ^ r_msb));

  assign full  = (depth_q == CW'(DEPTH));
  assign empty = (depth_q == '0);

  assign push_ok = bus.push & ~bus.pop & ~full;
  assign pop_ok  = bus.pop & ~bus.push & ~empty;
  assign misuse  = (bus.push & bus.pop) | (bus.push & full) | (bus.pop & empty);
  assign v_set   = bus.update & nv & ~pop_ok;

  assign push_idx = depth_q[IW-1:0];
  assign pop_idx  = push_idx - IW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q  <= 4'b0000;
      depth_q  <= '0;
      sticky_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (pop_ok)
        flags_q <= stack_mem[pop_idx];
      else if (bus.update)
        flags_q <= {nn, nz, nc, nv};

      if (push_ok)
        depth_q <= depth_q + CW'(1);
      else if (pop_ok)
        depth_q <= depth_q - CW'(1);

      if (v_set)
        sticky_q <= 1'b1;
      else if (bus.clr_sticky)
        sticky_q <= 1'b0;

      if (misuse)
        err_q <= 1'b1;
      else if (bus.clr_sticky)
        err_q <= 1'b0;
    end
  end

  // Stack storage is deliberately unreset; entries are only read after being pushed.
  always_ff @(posedge clk) begin
    if (push_ok)
      stack_mem[push_idx] <= flags_q;
  end

  always_comb begin
    cond_eval = 1'b0;
    case (bus.cond)
      4'h0: cond_eval = flags_q[2];
      4'h1: cond_eval = ~flags_q[2];
      4'h2: cond_eval = flags_q[1];
      4'h3: cond_eval = ~flags_q[1];
      4'h4: cond_eval = flags_q[3];
      4'h5: cond_eval = ~flags_q[3];
      4'h6: cond_eval = flags_q[0];
      4'h7: cond_eval = ~flags_q[0];
      4'h8: cond_eval = flags_q[1] & ~flags_q[2];
      4'h9: cond_eval = ~flags_q[1] | flags_q[2];
      4'hA: cond_eval = (flags_q[3] == flags_q[0]);
      4'hB: cond_eval = (flags_q[3] != flags_q[0]);
      4'hC: cond_eval = ~flags_q[2] & (flags_q[3] == flags_q[0]);
      4'hD: cond_eval = flags_q[2] | (flags_q[3] != flags_q[0]);
      4'hE: cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  end

  assign bus.n           = flags_q[3];
  assign bus.z           = flags_q[2];
  assign bus.c           = flags_q[1];
  assign bus.v           = flags_q[0];
  assign bus.sticky_v    = sticky_q;
  assign bus.stack_err   = err_q;
  assign bus.depth_cnt   = depth_q;
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
  assign bus.cond_true   = cond_eval;
endmodule

// File: tb/tb_flag_status_unit.sv
// Scoreboard bench for flag_status_unit: a 32-bit/4-deep instance against a reference model,
// plus an 8-bit/1-deep instance with directed checks.
module tb_flag_status_unit;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  flag_status_unit_if #(.WIDTH(32), .DEPTH(4)) bus32 ();
  flag_status_unit_if #(.WIDTH(8),  .DEPTH(1)) bus8 ();

  flag_status_unit #(.WIDTH(32), .DEPTH(4)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
  flag_status_unit #(.WIDTH(8),  .DEPTH(1)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

  typedef struct {
    logic [3:0] flags;
    logic       sticky;
    logic       err;
    int         depth;
    logic       ct;
  } exp_t;

  exp_t       sbq [$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] m_flags;
  logic       m_sticky;
  logic       m_err;
  int         m_depth;
  logic [3:0] m_stack [4];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Odd selectors are the complement of the even one below them.
  function automatic logic evalCond(input logic [3:0] f, input logic [3:0] cd);
    logic fn, fz, fc, fv, base;
    {fn, fz, fc, fv} = f;
    case (cd[3:1])
      3'd0: base = fz;
      3'd1: base = fc;
      3'd2: base = fn;
      3'd3: base = fv;
      3'd4: base = fc && !fz;
      3'd5: base = (fn == fv);
      3'd6: base = !fz && (fn == fv);
      default: base = 1'b1;
    endcase
    return cd[0] ? !base : base;
  endfunction

  task automatic modelReset();
    m_flags  = 4'b0000;
    m_sticky = 1'b0;
    m_err    = 1'b0;
    m_depth  = 0;
    sbq.delete();
  endtask

  task automatic checkQueue();
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
    end else begin
      e = sbq.pop_front();
      checkOutput("flags", 32'({bus32.n, bus32.z, bus32.c, bus32.v}), 32'(e.flags));
      checkOutput("sticky_v", 32'(bus32.sticky_v), 32'(e.sticky));
      checkOutput("stack_err", 32'(bus32.stack_err), 32'(e.err));
      checkOutput("depth_cnt", 32'(bus32.depth_cnt), 32'(e.depth));
      checkOutput("stack_full", 32'(bus32.stack_full), 32'(e.depth == 4));
      checkOutput("stack_empty", 32'(bus32.stack_empty), 32'(e.depth == 0));
      checkOutput("cond_true", 32'(bus32.cond_true), 32'(e.ct));
    end
  endtask

  task automatic applyStimulus(input logic [31:0] r, input logic [31:0] a, input logic [31:0] b,
                               input logic ci, input logic is_sub, input logic upd,
                               input logic ps, input logic pp, input logic clr,
                               input logic [3:0] cd);
    exp_t       e;
    logic       ov, popped, bad;
    logic [3:0] nf;
    @(negedge clk);
    bus32.result = r;    bus32.op_a = a;     bus32.op_b = b;
    bus32.carry_in = ci; bus32.sub = is_sub; bus32.update = upd;
    bus32.push = ps;     bus32.pop = pp;     bus32.clr_sticky = clr;
    bus32.cond = cd;
    if (is_sub) ov = (a[31] != b[31]) && (r[31] != a[31]);
    else        ov = (a[31] == b[31]) && (r[31] != a[31]);
    nf     = {r[31], (r == 32'd0), ci, ov};
    popped = 1'b0;
    bad    = 1'b0;
    if (ps && pp) begin
      bad = 1'b1;
    end else if (ps) begin
      if (m_depth == 4) bad = 1'b1;
      else begin
        m_stack[m_depth] = m_flags;
        m_depth++;
      end
    end else if (pp) begin
      if (m_depth == 0) bad = 1'b1;
      else begin
        m_depth--;
        popped = 1'b1;
      end
    end
    if (popped) m_flags = m_stack[m_depth];
    else if (upd) begin
      m_flags = nf;
      if (ov) m_sticky = 1'b1;
      else if (clr) m_sticky = 1'b0;
    end else if (clr) m_sticky = 1'b0;
    if (popped && clr) m_sticky = 1'b0;
    if (bad) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    e.flags = m_flags; e.sticky = m_sticky; e.err = m_err; e.depth = m_depth;
    e.ct = evalCond(m_flags, cd);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    checkQueue();
  endtask

  task automatic idle(input logic [3:0] cd);
    applyStimulus(32'h1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cd);
  endtask

  task automatic checkReset32(input string tag);
    checkOutput({tag, "_flags"}, 32'({bus32.n, bus32.z, bus32.c, bus32.v}), 32'h0);
    checkOutput({tag, "_sticky"}, 32'(bus32.sticky_v), 32'h0);
    checkOutput({tag, "_err"}, 32'(bus32.stack_err), 32'h0);
    checkOutput({tag, "_depth"}, 32'(bus32.depth_cnt), 32'h0);
    checkOutput({tag, "_empty"}, 32'(bus32.stack_empty), 32'h1);
    checkOutput({tag, "_full"}, 32'(bus32.stack_full), 32'h0);
  endtask

  task automatic checkConds8(input string tag);
    bus8.cond = 4'hE;
    #1 checkOutput({tag, "_condE"}, 32'(bus8.cond_true), 32'h1);
    bus8.cond = 4'hF;
    #1 checkOutput({tag, "_condF"}, 32'(bus8.cond_true), 32'h0);
  endtask

  task automatic step8(input logic [7:0] r, input logic upd, input logic ps, input logic pp);
    @(negedge clk);
    bus8.result = r; bus8.update = upd; bus8.push = ps; bus8.pop = pp;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] pop_order [4];
    pop_order = '{4'b0100, 4'b1011, 4'b0000, 4'b0110};

    rst_n = 1'b0;
    bus32.result = '0; bus32.op_a = '0; bus32.op_b = '0; bus32.carry_in = 1'b0;
    bus32.sub = 1'b0; bus32.update = 1'b0; bus32.push = 1'b0; bus32.pop = 1'b0;
    bus32.clr_sticky = 1'b0; bus32.cond = 4'h0;
    bus8.result = '0; bus8.op_a = '0; bus8.op_b = '0; bus8.carry_in = 1'b0;
    bus8.sub = 1'b0; bus8.update = 1'b0; bus8.push = 1'b0; bus8.pop = 1'b0;
    bus8.clr_sticky = 1'b0; bus8.cond = 4'hE;
    modelReset();
    #3;
    checkReset32("rst");
    checkOutput("rst8_depth", 32'(bus8.depth_cnt), 32'h0);
    checkOutput("rst8_empty", 32'(bus8.stack_empty), 32'h1);
    #9 rst_n = 1'b1;

    // Signed add overflow into the sign bit.
    applyStimulus(32'h8000_0000, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h6);
    checkOutput("add_flags", 32'({bus32.n, bus32.z, bus32.c, bus32.v}), 32'b1001);
    checkOutput("add_sticky", 32'(bus32.sticky_v), 32'h1);
    checkOutput("add_cond6", 32'(bus32.cond_true), 32'h1);

    // Equal-operand subtract.
    applyStimulus(32'h0, 32'h5, 32'h5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    checkOutput("sub_flags", 32'({bus32.n, bus32.z, bus32.c, bus32.v}), 32'b0110);
    checkOutput("sub_cond0", 32'(bus32.cond_true), 32'h1);
    idle(4'h8);
    checkOutput("sub_cond8", 32'(bus32.cond_true), 32'h0);
    idle(4'h9);
    checkOutput("sub_cond9", 32'(bus32.cond_true), 32'h1);

    // Fill the stack with push+update so each push saves the pre-update flags.
    applyStimulus(32'h1, 32'h0, 32'h1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'hE);
    applyStimulus(32'h8000_0000, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'hA);
    applyStimulus(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'hC);
    applyStimulus(32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h4);
    checkOutput("fill_full", 32'(bus32.stack_full), 32'h1);
    applyStimulus(32'h1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h3);
    checkOutput("overpush_err", 32'(bus32.stack_err), 32'h1);
    checkOutput("overpush_depth", 32'(bus32.depth_cnt), 32'h4);
    applyStimulus(32'h1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
    checkOutput("clr_sticky", 32'(bus32.sticky_v), 32'h0);
    checkOutput("clr_err", 32'(bus32.stack_err), 32'h0);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(32'h1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hB);
      checkOutput($sformatf("pop%0d_flags", i), 32'({bus32.n, bus32.z, bus32.c, bus32.v}),
                  32'(pop_order[i]));
    end
    applyStimulus(32'h1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hD);
    checkOutput("underpop_flags", 32'({bus32.n, bus32.z, bus32.c, bus32.v}), 32'b0110);
    checkOutput("underpop_err", 32'(bus32.stack_err), 32'h1);

    // Simultaneous pop+update and push+pop.
    applyStimulus(32'h1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h0);
    applyStimulus(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    applyStimulus(32'h8000_0000, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
    checkOutput("popupd_flags", 32'({bus32.n, bus32.z, bus32.c, bus32.v}), 32'b0110);
    applyStimulus(32'h1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h0);
    applyStimulus(32'h1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    checkOutput("pushpop_depth", 32'(bus32.depth_cnt), 32'h1);
    checkOutput("pushpop_err", 32'(bus32.stack_err), 32'h1);

    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom, $urandom, $urandom, 1'($urandom), 1'($urandom),
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                    1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0),
                    4'($urandom));
    end

    // Mid-sequence asynchronous reset with depth 2 and v set.
    applyStimulus(32'h1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
    while (m_depth > 0)
      applyStimulus(32'h1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    applyStimulus(32'h8000_0000, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h6);
    applyStimulus(32'h1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h6);
    checkOutput("prerst_depth", 32'(bus32.depth_cnt), 32'h2);
    checkOutput("prerst_v", 32'(bus32.v), 32'h1);
    #2 rst_n = 1'b0;
    #1 checkReset32("async");
    modelReset();
    bus32.push = 1'b0; bus32.pop = 1'b0; bus32.update = 1'b0; bus32.clr_sticky = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    applyStimulus(32'h1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    checkOutput("postrst_err", 32'(bus32.stack_err), 32'h1);

    // Narrow, single-entry instance.
    checkConds8("s0");
    step8(8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("w8_z", 32'(bus8.z), 32'h1);
    checkConds8("s1");
    step8(8'h80, 1'b0, 1'b1, 1'b0);
    checkOutput("w8_full", 32'(bus8.stack_full), 32'h1);
    checkConds8("s2");
    step8(8'h80, 1'b0, 1'b1, 1'b0);
    checkOutput("w8_err", 32'(bus8.stack_err), 32'h1);
    checkOutput("w8_depth", 32'(bus8.depth_cnt), 32'h1);
    checkConds8("s3");
    step8(8'h80, 1'b1, 1'b0, 1'b1);
    checkOutput("w8_pop_z", 32'(bus8.z), 32'h1);
    checkOutput("w8_pop_n", 32'(bus8.n), 32'h0);
    checkConds8("s4");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
